vram_touch_painter: RTL and testbench

//  Upstream producer for the display controller's video RAM: turns FT6206 touch samples into

---
 rtl/vram_touch_painter.sv | 140 ++++++++++++++
 tb/tb_vram_touch_painter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/vram_touch_painter.sv
// vram_touch_painter: turns touch samples into BRUSH x BRUSH pen squares on the VRAM write port
// and runs full-screen clear sweeps; every write-port output is registered.
package vram_touch_painter_pkg;
    typedef struct packed {
        logic        valid;
        logic [11:0] x;
        logic [11:0] y;
    } touch_t;
endpackage

module vram_touch_painter
    import vram_touch_painter_pkg::*;
#(
    parameter int          DISPLAY_WIDTH  = 240,
    parameter int          DISPLAY_HEIGHT = 320,
    parameter int          BRUSH          = 4,
    parameter logic [15:0] CLEAR_COLOR    = 16'h0000,
    localparam int         VRAM_L         = DISPLAY_WIDTH * DISPLAY_HEIGHT,
    localparam int         AW             = $clog2(VRAM_L)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  touch_t        touch,
    input  logic [15:0]   pen_color,
    input  logic          clear_req,
    output logic          vram_wr_ena,
    output logic [AW-1:0] vram_wr_addr,
    output logic [15:0]   vram_wr_data,
    output logic          busy,
    output logic          clear_done
);
    typedef enum logic [1:0] {S_IDLE, S_PAINT, S_CLEAR} state_t;

    localparam logic [AW-1:0] PAINT_LAST = AW'(BRUSH * BRUSH - 1);
    localparam logic [AW-1:0] CLEAR_LAST = AW'(VRAM_L - 1);
    localparam logic [11:0]   ALIGN      = ~12'(BRUSH - 1);
    localparam logic [11:0]   W          = 12'(DISPLAY_WIDTH);
    localparam logic [11:0]   H          = 12'(DISPLAY_HEIGHT);

    state_t        state, nxt_state;
    logic [AW-1:0] cnt, nxt_cnt;
    logic [11:0]   bx, by, nxt_bx, nxt_by;
    logic [15:0]   color, nxt_color;
    logic          last_v, nxt_last_v;
    logic          pend, nxt_pend;
    logic [11:0]   tbx, tby, px, py;
    logic          in_range, repeat_blk;
    logic          nxt_wr_ena, nxt_done;
    logic [AW-1:0] nxt_wr_addr;
    logic [15:0]   nxt_wr_data;

    // bx/by/color double as the last-block register used to drop repeated touches
    assign tbx        = touch.x & ALIGN;
    assign tby        = touch.y & ALIGN;
    assign in_range   = (touch.x < W) && (touch.y < H);
    assign repeat_blk = last_v && (tbx == bx) && (tby == by) && (pen_color == color);
    assign busy       = (state != S_IDLE) || pend;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            bx           <= '0;
            by           <= '0;
            color        <= '0;
            last_v       <= 1'b0;
            pend         <= 1'b0;
            vram_wr_ena  <= 1'b0;
            vram_wr_addr <= '0;
            vram_wr_data <= '0;
            clear_done   <= 1'b0;
        end else begin
            state        <= nxt_state;
            cnt          <= nxt_cnt;
            bx           <= nxt_bx;
            by           <= nxt_by;
            color        <= nxt_color;
            last_v       <= nxt_last_v;
            pend         <= nxt_pend;
            vram_wr_ena  <= nxt_wr_ena;
            vram_wr_addr <= nxt_wr_addr;
            vram_wr_data <= nxt_wr_data;
            clear_done   <= nxt_done;
        end
    end

    always_comb begin
        nxt_state  = state;
        nxt_cnt    = cnt;
        nxt_bx     = bx;
        nxt_by     = by;
        nxt_color  = color;
        nxt_last_v = last_v;
        nxt_pend   = pend;
        if (!ena)
            nxt_pend = pend | (clear_req && state != S_CLEAR);
        else
            case (state)
                S_IDLE:
                    if (pend || clear_req) begin
                        nxt_state  = S_CLEAR;
                        nxt_cnt    = '0;
                        nxt_pend   = 1'b0;
                        nxt_last_v = 1'b0;
                    end else if (touch.valid && in_range && !repeat_blk) begin
                        nxt_state  = S_PAINT;
                        nxt_cnt    = '0;
                        nxt_bx     = tbx;
                        nxt_by     = tby;
                        nxt_color  = pen_color;
                        nxt_last_v = 1'b1;
                    end
                S_PAINT: begin
                    nxt_pend = pend | clear_req;
                    if (cnt == PAINT_LAST)
                        nxt_state = S_IDLE;
                    else
                        nxt_cnt = cnt + 1'b1;
                end
                S_CLEAR:
                    if (cnt == CLEAR_LAST)
                        nxt_state = S_IDLE;
                    else
                        nxt_cnt = cnt + 1'b1;
                default: nxt_state = S_IDLE;
            endcase
    end

    // the write for the next cycle is derived from the next state, so the first write
    // lands the cycle after acceptance
    always_comb begin
        px          = nxt_bx + 12'(nxt_cnt % AW'(BRUSH));
        py          = nxt_by + 12'(nxt_cnt / AW'(BRUSH));
        nxt_wr_ena  = ena && (nxt_state == S_CLEAR || (nxt_state == S_PAINT && px < W && py < H));
        nxt_wr_addr = (nxt_state == S_CLEAR) ? nxt_cnt : AW'(py) * AW'(DISPLAY_WIDTH) + AW'(px);
        nxt_wr_data = (nxt_state == S_CLEAR) ? CLEAR_COLOR : nxt_color;
        nxt_done    = ena && state == S_CLEAR && nxt_state == S_IDLE;
    end
endmodule

// File: tb/tb_vram_touch_painter.sv
// tb_vram_touch_painter: randomized scoreboard bench; a pixel-level model queues expected writes
// and a negedge monitor pops and compares every strobed write and clear_done pulse.
module tb_vram_touch_painter;
    import vram_touch_painter_pkg::*;

    localparam int W = 240;
    localparam int H = 320;
    localparam int B = 4;
    localparam int L = W * H;

    typedef struct {
        int          addr;
        logic [15:0] data;
        bit          clr;
        bit          last;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ena = 1'b0;
    logic        clear_req = 1'b0;
    touch_t      touch = '0;
    logic [15:0] pen_color = '0;
    logic        vram_wr_ena;
    logic [16:0] vram_wr_addr;
    logic [15:0] vram_wr_data;
    logic        busy;
    logic        clear_done;

    wr_t         q[$];
    wr_t         e;
    int          checks = 0;
    int          passes = 0;
    int          clr_seen = 0;
    bit          done_exp = 1'b0;
    bit          done_nxt;
    bit          m_last_v = 1'b0;
    bit          m_acc;
    int          m_bx, m_by;
    logic [15:0] m_c;
    logic [15:0] pens[3] = '{16'hF800, 16'h07E0, 16'h001F};

    vram_touch_painter dut (
        .clk(clk),
        .rst(rst),
        .ena(ena),
        .touch(touch),
        .pen_color(pen_color),
        .clear_req(clear_req),
        .vram_wr_ena(vram_wr_ena),
        .vram_wr_addr(vram_wr_addr),
        .vram_wr_data(vram_wr_data),
        .busy(busy),
        .clear_done(clear_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    always @(negedge clk) begin
        if (!rst) done_exp = 1'b0;
        else begin
            done_nxt = 1'b0;
            if (vram_wr_ena) begin
                if (q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_write: addr %0d data %0h, expected no write", vram_wr_addr, vram_wr_data);
                end else begin
                    e = q.pop_front();
                    chk("write_addr_data", {vram_wr_addr, vram_wr_data}, {e.addr[16:0], e.data});
                    if (e.clr) clr_seen++;
                    done_nxt = e.last;
                end
            end
            if (clear_done || done_exp) chk("clear_done", clear_done, done_exp);
            done_exp = done_nxt;
        end
    end

    task automatic push_clear();
        for (int a = 0; a < L; a++) q.push_back('{a, 16'h0000, 1'b1, a == L - 1});
        m_last_v = 1'b0;
    endtask

    // Reference: a clear wins; else an on-screen touch paints its aligned square unless it
    // repeats the last block and colour; off-screen pixels of the square are skipped.
    task automatic model_touch(input int x, input int y, input logic [15:0] c, input bit clr);
        int bx, by;
        bx = x / B * B;
        by = y / B * B;
        m_acc = 1'b0;
        if (clr) begin
            push_clear();
            m_acc = 1'b1;
        end else if (x < W && y < H && !(m_last_v && bx == m_bx && by == m_by && c == m_c)) begin
            for (int dy = 0; dy < B; dy++)
                for (int dx = 0; dx < B; dx++)
                    if (bx + dx < W && by + dy < H) q.push_back('{(by + dy) * W + bx + dx, c, 1'b0, 1'b0});
            m_last_v = 1'b1;
            m_bx = bx;
            m_by = by;
            m_c = c;
            m_acc = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_touch(input int x, input int y, input logic [15:0] c, input bit clr, input bit live);
        ena = 1'b1;
        touch.valid = 1'b1;
        touch.x = 12'(x);
        touch.y = 12'(y);
        pen_color = c;
        clear_req = clr;
        if (live) model_touch(x, y, c, clr);
        tick();
        touch.valid = 1'b0;
        clear_req = 1'b0;
        pen_color = 16'($urandom);
        if (live) chk("accept_vs_busy", busy, m_acc);
    endtask

    task automatic wait_idle(input int limit, input bit rnd);
        int n = 0;
        while (busy && n < limit) begin
            if (rnd) ena = ($urandom_range(0, 3) != 0);
            tick();
            n++;
        end
        ena = 1'b1;
        if (busy) begin
            checks++;
            $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", limit);
        end
    endtask

    initial begin
        int n, x, y, lx, ly;
        logic [15:0] c;
        repeat (3) tick();
        chk("reset_wr_ena", vram_wr_ena, 0);
        chk("reset_wr_addr", vram_wr_addr, 0);
        chk("reset_wr_data", vram_wr_data, 0);
        chk("reset_busy", busy, 0);
        chk("reset_clear_done", clear_done, 0);
        rst = 1'b1;
        ena = 1'b1;
        tick();
        do_touch(10, 21, 16'hF800, 1'b0, 1'b1);
        chk("first_write_latency", vram_wr_ena, 1);
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
        chk("paint_busy_cycles", n, 16);
        do_touch(10, 21, 16'hF800, 1'b0, 1'b1);
        do_touch(9, 21, 16'hF800, 1'b0, 1'b1);
        do_touch(9, 21, 16'h07E0, 1'b0, 1'b1);
        wait_idle(100, 1'b0);
        do_touch(238, 318, 16'h07E0, 1'b0, 1'b1);
        do_touch(1, 1, 16'h1234, 1'b0, 1'b0);
        wait_idle(100, 1'b0);
        do_touch(240, 318, 16'h07E0, 1'b0, 1'b1);
        do_touch(100, 320, 16'h07E0, 1'b0, 1'b1);
        do_touch(50, 60, 16'hF800, 1'b1, 1'b1);
        repeat (100) tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        wait_idle(L + 100, 1'b0);
        tick();
        do_touch(238, 318, 16'h07E0, 1'b0, 1'b1);
        wait_idle(100, 1'b0);
        lx = 0;
        ly = 0;
        for (int i = 0; i < 40; i++) begin
            wait_idle(200, 1'b1);
            c = pens[$urandom_range(0, 2)];
            if (i > 0 && $urandom_range(0, 2) == 0) begin
                x = lx / B * B + $urandom_range(0, 3);
                y = ly / B * B + $urandom_range(0, 3);
            end else begin
                x = $urandom_range(0, 259);
                y = $urandom_range(0, 335);
            end
            lx = x;
            ly = y;
            do_touch(x, y, c, 1'b0, 1'b1);
            if (busy && $urandom_range(0, 1) == 1) do_touch($urandom_range(0, 239), $urandom_range(0, 319), 16'hABCD, 1'b0, 1'b0);
        end
        wait_idle(200, 1'b1);
        clr_seen = 0;
        do_touch(100, 100, 16'h001F, 1'b0, 1'b1);
        tick();
        tick();
        clear_req = 1'b1;
        push_clear();
        tick();
        clear_req = 1'b0;
        n = 0;
        while (clr_seen < 1000 && n < 5000) begin
            ena = $urandom_range(0, 1);
            tick();
            n++;
        end
        chk("clear_reached_1000", clr_seen >= 1000, 1);
        #2 rst = 1'b0;
        #1;
        chk("midclear_reset_wr_ena", vram_wr_ena, 0);
        chk("midclear_reset_busy", busy, 0);
        q.delete();
        m_last_v = 1'b0;
        ena = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_reset_idle", {busy, vram_wr_ena, clear_done}, 0);
        end
        do_touch(100, 100, 16'h001F, 1'b0, 1'b1);
        wait_idle(100, 1'b0);
        tick();
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
